// File: rtl/stepper_axis_if.sv
// Command channel of the stepper axis: absolute target plus step mode,
// transferred on a valid/ready handshake.
interface stepper_axis_if #(
    parameter int POS_W = 14
) ();
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic signed [POS_W-1:0] cmd_target;
    logic                    half_step;

    modport master (output cmd_valid, output cmd_target, output half_step, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_target, input half_step, output cmd_ready);
endinterface

// File: rtl/stepper_axis_ctrl.sv
// Single-axis stepper controller: absolute moves with a linear trapezoidal
// step-interval ramp, controlled abort and full/half-step phase sequencing.
module stepper_axis_ctrl #(
    parameter int POS_W        = 14,
    parameter int DIV_W        = 20,
    parameter int PERIOD_START = 262144,
    parameter int PERIOD_MIN   = 65536,
    parameter int RAMP_DEC     = 4096,
    parameter bit HOLD_IDLE    = 1'b0
) (
    input  logic                    clk,
    input  logic                    reset,
    stepper_axis_if.slave           cmd,
    input  logic                    abort,
    output logic [3:0]              coil,
    output logic signed [POS_W-1:0] position,
    output logic                    busy,
    output logic                    done
);
    localparam int RW = POS_W + 1;
    localparam logic [DIV_W-1:0] P_START   = DIV_W'(PERIOD_START);
    localparam logic [DIV_W-1:0] P_MIN     = DIV_W'(PERIOD_MIN);
    localparam logic [DIV_W-1:0] ONE_D     = DIV_W'(1);
    localparam logic [DIV_W:0]   P_START_X = (DIV_W+1)'(PERIOD_START);
    localparam logic [DIV_W:0]   P_MIN_X   = (DIV_W+1)'(PERIOD_MIN);
    localparam logic [DIV_W:0]   DEC_X     = (DIV_W+1)'(RAMP_DEC);
    localparam logic [RW-1:0]    ONE_R     = RW'(1);
    localparam logic [RW-1:0]    TWO_R     = RW'(2);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [3:0] phase_of(input logic [2:0] idx);
        case (idx)
            3'd0:    phase_of = 4'b1000;
            3'd1:    phase_of = 4'b1100;
            3'd2:    phase_of = 4'b0100;
            3'd3:    phase_of = 4'b0110;
            3'd4:    phase_of = 4'b0010;
            3'd5:    phase_of = 4'b0011;
            3'd6:    phase_of = 4'b0001;
            3'd7:    phase_of = 4'b1001;
            default: phase_of = 4'b0000;
        endcase
    endfunction

    state_t                  state_r;
    logic signed [POS_W-1:0] position_r, target_r;
    logic                    half_r, aborting_r, ready_r, busy_r, done_r;
    logic [DIV_W-1:0]        interval_r, cnt_r;
    logic [RW-1:0]           ramp_r;
    logic [3:0]              coil_r;

    logic signed [RW-1:0]    dist_s;
    logic [RW-1:0]           abs_s, step_sz_s, new_abs_s, rem_s, half_up_s, ramp_dn_s;
    logic signed [POS_W-1:0] next_pos_s;
    logic [DIV_W:0]          up_x_s;
    logic [DIV_W-1:0]        int_up_s, int_dn_s;
    logic                    dir_neg_s, expire_s, abort_eff_s;

    // Step geometry and ramp arithmetic for the step the counter is timing
    always_comb begin
        dist_s      = $signed({target_r[POS_W-1], target_r}) - $signed({position_r[POS_W-1], position_r});
        dir_neg_s   = dist_s[RW-1];
        abs_s       = dir_neg_s ? (RW'(0) - dist_s) : dist_s;
        step_sz_s   = (!half_r && (abs_s >= TWO_R)) ? TWO_R : ONE_R;
        new_abs_s   = abs_s - step_sz_s;
        half_up_s   = new_abs_s + ONE_R;
        // Full-step mode counts a trailing odd half-step as one more step
        rem_s       = half_r ? new_abs_s : {1'b0, half_up_s[RW-1:1]};
        next_pos_s  = dir_neg_s ? (position_r - POS_W'(step_sz_s)) : (position_r + POS_W'(step_sz_s));
        expire_s    = (cnt_r == (interval_r - ONE_D));
        abort_eff_s = aborting_r | abort;
        up_x_s      = {1'b0, interval_r} + DEC_X;
        int_up_s    = (up_x_s > P_START_X) ? P_START : up_x_s[DIV_W-1:0];
        if ({1'b0, interval_r} >= (P_MIN_X + DEC_X)) begin
            int_dn_s = interval_r - DEC_X[DIV_W-1:0];
        end else begin
            int_dn_s = P_MIN;
        end
        ramp_dn_s   = (ramp_r == RW'(0)) ? RW'(0) : (ramp_r - ONE_R);
    end

    // Move sequencer: accept, interval timing, ramp decisions and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            position_r <= '0;
            target_r   <= '0;
            half_r     <= 1'b0;
            aborting_r <= 1'b0;
            ready_r    <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            interval_r <= P_START;
            cnt_r      <= '0;
            ramp_r     <= '0;
            coil_r     <= 4'b0000;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    if (cmd.cmd_valid && ready_r) begin
                        target_r   <= cmd.cmd_target;
                        half_r     <= cmd.half_step;
                        interval_r <= P_START;
                        cnt_r      <= '0;
                        ramp_r     <= '0;
                        aborting_r <= 1'b0;
                        ready_r    <= 1'b0;
                        coil_r     <= phase_of(position_r[2:0]);
                        if (cmd.cmd_target == position_r) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r <= RUN;
                            busy_r  <= 1'b1;
                        end
                    end else begin
                        coil_r <= HOLD_IDLE ? phase_of(position_r[2:0]) : 4'b0000;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborting_r <= 1'b1;
                    end
                    if (expire_s) begin
                        cnt_r      <= '0;
                        position_r <= next_pos_s;
                        coil_r     <= phase_of(next_pos_s[2:0]);
                        if (rem_s == RW'(0)) begin
                            state_r <= DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end else if (abort_eff_s || (rem_s <= ramp_r)) begin
                            interval_r <= int_up_s;
                            ramp_r     <= ramp_dn_s;
                            // An abort ends the move once the ramp has unwound
                            if (abort_eff_s && (ramp_dn_s == RW'(0))) begin
                                state_r <= DONE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                            end
                        end else if (interval_r > P_MIN) begin
                            interval_r <= int_dn_s;
                            ramp_r     <= ramp_r + ONE_R;
                        end
                    end else begin
                        cnt_r <= cnt_r + ONE_D;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    done_r     <= 1'b0;
                    busy_r     <= 1'b0;
                    ready_r    <= 1'b1;
                    aborting_r <= 1'b0;
                    coil_r     <= HOLD_IDLE ? phase_of(position_r[2:0]) : 4'b0000;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                    coil_r  <= 4'b0000;
                end
            endcase
        end
    end

    assign cmd.cmd_ready = ready_r;
    assign coil          = coil_r;
    assign position      = position_r;
    assign busy          = busy_r;
    assign done          = done_r;
endmodule

// File: tb/tb_stepper_axis_ctrl.sv
// Bench for stepper_axis_ctrl: directed moves from the test plan plus random
// moves, checked cycle by cycle against a trajectory planned from the move rules.
module tb_stepper_axis_ctrl;
    localparam int POS_W = 14, DIV_W = 20, P_START = 10, P_MIN = 4, R_DEC = 2;
    localparam int NONE = 1 << 30;
    localparam logic [3:0] PH [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                      4'b0010, 4'b0011, 4'b0001, 4'b1001};

    logic clk = 1'b0;
    logic reset, abort, busy, done;
    logic [3:0] coil;
    logic signed [POS_W-1:0] position;

    stepper_axis_if #(.POS_W(POS_W)) cmd_bus ();

    stepper_axis_ctrl #(.POS_W(POS_W), .DIV_W(DIV_W), .PERIOD_START(P_START),
                        .PERIOD_MIN(P_MIN), .RAMP_DEC(R_DEC), .HOLD_IDLE(1'b0)) dut (
        .clk(clk), .reset(reset), .cmd(cmd_bus), .abort(abort),
        .coil(coil), .position(position), .busy(busy), .done(done));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int m_pos = 0;
    int st_t[$], st_p[$], obs_t[$];

    task automatic chk_val(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Planned trajectory: step edges (cycles after accept) and positions after each step
    task automatic plan_move(input int tgt, input bit hs, input int ab_edge, output int t_last);
        int pos, t, iv, rmp, d, s, rem;
        bit fin;
        st_t.delete();
        st_p.delete();
        pos = m_pos; t = 0; iv = P_START; rmp = 0;
        fin = (tgt == pos);
        while (!fin) begin
            t += iv;
            d = (tgt > pos) ? tgt - pos : pos - tgt;
            s = (!hs && d >= 2) ? 2 : 1;
            pos += (tgt > pos) ? s : -s;
            d = (tgt > pos) ? tgt - pos : pos - tgt;
            rem = hs ? d : (d + 1) / 2;
            st_t.push_back(t);
            st_p.push_back(pos);
            if (rem == 0) begin
                fin = 1'b1;
            end else if (t >= ab_edge || rem <= rmp) begin
                iv = (iv + R_DEC > P_START) ? P_START : iv + R_DEC;
                rmp = (rmp > 0) ? rmp - 1 : 0;
                if (t >= ab_edge && rmp == 0) fin = 1'b1;
            end else if (iv > P_MIN) begin
                iv = (iv - R_DEC < P_MIN) ? P_MIN : iv - R_DEC;
                rmp++;
            end
        end
        t_last = t;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        abort = 1'b0;
        cmd_bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        chk_val("rst_position", $signed(position), 0);
        chk_val("rst_coil", coil, 0);
        chk_val("rst_busy", busy, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_ready", cmd_bus.cmd_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        m_pos = 0;
        @(posedge clk); #1;
        chk_val("rst_no_done", done, 0);
        @(negedge clk);
    endtask

    // noise: 0 = cmd_valid low after accept, 1 = random, 2 = held high
    task automatic run_move(input int tgt, input bit hs, input int ab_edge, input int rst_edge, input int noise);
        int t_last, k, exp_pos, prev;
        plan_move(tgt, hs, ab_edge, t_last);
        obs_t.delete();
        k = 0; exp_pos = m_pos; prev = m_pos;
        @(negedge clk);
        chk_val("ready_pre", cmd_bus.cmd_ready, 1);
        cmd_bus.cmd_valid  = 1'b1;
        cmd_bus.cmd_target = POS_W'(tgt);
        cmd_bus.half_step  = hs;
        for (int e = 0; e <= t_last + 1; e++) begin
            @(posedge clk); #1;
            while (k < st_t.size() && st_t[k] <= e) begin
                exp_pos = st_p[k];
                k++;
            end
            if (int'($signed(position)) != prev) begin
                obs_t.push_back(e);
                prev = $signed(position);
            end
            chk_val("position", $signed(position), exp_pos);
            chk_val("coil", coil, (e <= t_last) ? PH[exp_pos & 7] : 4'b0000);
            chk_val("busy", busy, e < t_last);
            chk_val("done", done, e == t_last);
            chk_val("ready", cmd_bus.cmd_ready, e == t_last + 1);
            @(negedge clk);
            if (e == rst_edge) begin
                pulse_reset();
                return;
            end
            cmd_bus.cmd_valid  = (noise == 2) ? 1'b1 : ((noise == 1) ? 1'($urandom) : 1'b0);
            cmd_bus.cmd_target = POS_W'($urandom);
            cmd_bus.half_step  = 1'($urandom);
            if (e + 1 >= ab_edge) abort = 1'b1;
        end
        cmd_bus.cmd_valid = 1'b0;
        abort = 1'b0;
        m_pos = exp_pos;
    endtask

    initial begin
        reset = 1'b1;
        abort = 1'b0;
        cmd_bus.cmd_valid  = 1'b0;
        cmd_bus.cmd_target = '0;
        cmd_bus.half_step  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_val("reset_coil", coil, 0);
        chk_val("reset_position", $signed(position), 0);
        chk_val("reset_ready", cmd_bus.cmd_ready, 1);
        chk_val("reset_busy", busy, 0);
        chk_val("reset_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        m_pos = 0;

        // Zero distance with cmd_valid held through the DONE cycle
        run_move(0, 1'b1, NONE, -1, 2);
        chk_val("zero_steps", obs_t.size(), 0);

        // Half-step move to 5
        run_move(5, 1'b1, NONE, -1, 0);
        chk_val("half_nsteps", obs_t.size(), 5);
        if (obs_t.size() == 5) begin
            chk_val("half_t0", obs_t[0], 10);
            chk_val("half_t1", obs_t[1], 18);
            chk_val("half_t2", obs_t[2], 24);
            chk_val("half_t3", obs_t[3], 32);
            chk_val("half_t4", obs_t[4], 42);
        end
        chk_val("half_final", $signed(position), 5);

        // Full-step move from 0 to -6
        @(negedge clk);
        pulse_reset();
        run_move(-6, 1'b0, NONE, -1, 0);
        chk_val("full_nsteps", obs_t.size(), 3);
        if (obs_t.size() == 3) begin
            chk_val("full_t0", obs_t[0], 10);
            chk_val("full_t1", obs_t[1], 18);
            chk_val("full_t2", obs_t[2], 28);
        end
        chk_val("full_final", $signed(position), -6);

        // Abort once cruising (after the third step)
        pulse_reset();
        run_move(100, 1'b1, 25, -1, 0);
        chk_val("abort_final", $signed(position), 6);
        chk_val("abort_last_step", (obs_t.size() > 0) ? obs_t[obs_t.size()-1] : -1, 42);

        // Reset at the third step edge, then a normal move
        run_move(20, 1'b1, NONE, 24, 0);
        run_move(3, 1'b0, NONE, -1, 1);

        for (int i = 0; i < 40; i++) begin
            int tgt, ab;
            tgt = m_pos + int'($urandom_range(0, 40)) - 20;
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : NONE;
            run_move(tgt, 1'($urandom), ab, -1, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stepper_axis_ctrl.md
# stepper_axis_ctrl

Parametrised single-axis stepper motion controller. It succeeds the fixed-table step_motor_drive stepper state machine. It accepts absolute signed targets over a valid/ready handshake and drives one bipolar motor through full-step or half-step phase tables. Moves use a linear trapezoidal acceleration/deceleration ramp, with controlled abort and optional holding torque at idle. It sits between the digit-to-position decode and the coil driver pins.

## Interface
- POS_W, 14, signed position/target width, in half-step units
- DIV_W, 20, step-interval counter width
- PERIOD_START, 262144, first and last step interval in clk cycles (slowest rate)
- PERIOD_MIN, 65536, cruise step interval (fastest rate), PERIOD_MIN <= PERIOD_START
- RAMP_DEC, 4096, interval change per step while ramping
- HOLD_IDLE, 0, 1 = coils stay energised at idle; 0 = coils 0000 at idle
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high in IDLE only
- cmd_target  in  POS_W  signed absolute target
- half_step  in  1  mode: 1 = 1 unit per step, 0 = 2 units per step; sampled at accept
- abort  in  1  level; begins controlled deceleration
- coil  out  4  {A1,B1,A2,B2}
- position  out  POS_W  signed current position
- busy  out  1  move in progress
- done  out  1  one-cycle pulse at move end

## Operation
- States:
  - IDLE: cmd_ready = 1.
  - RUN: stepping.
  - DONE: one cycle; done = 1; then returns to IDLE.
- Accept happens on a clk edge with cmd_valid & cmd_ready. At accept:
  - Latch target and mode.
  - Load interval = PERIOD_START; clear the interval counter.
  - Set ramp_steps = 0.
- If target == position at accept, go IDLE -> DONE with no step.
- Otherwise go to RUN.
- RUN behaviour:
  - The counter counts to the current interval. On expiry, one step is taken and the counter clears.
  - Step size is 2 when half_step = 0 and |remaining| >= 2; otherwise it is 1.
  - Direction is the sign of (target - position).
- Distance is computed in POS_W+1 bits and is never truncated.
- After each step, let rem = remaining steps in the current mode. For full-step mode, rem = ceil(|target - position| / 2).
  - rem == 0: go to DONE.
  - rem <= ramp_steps, or aborting: decelerate. Interval = min(interval + RAMP_DEC, PERIOD_START); ramp_steps -= 1 (floor 0).
  - Else if interval > PERIOD_MIN: accelerate. Interval = max(interval - RAMP_DEC, PERIOD_MIN); ramp_steps += 1.
  - Else: cruise; interval unchanged.
- Abort in RUN sets the aborting flag, which holds until DONE.
  - Each subsequent step decelerates.
  - After a step at which ramp_steps == 0 (checked after that step's decrement), go to DONE. Position at that point is short of target.
  - Abort sampled at a step edge also applies to that step's ramp decision.
  - Abort in IDLE or DONE is ignored.
- Phase table is indexed by position[2:0]:
  - 0: 1000
  - 1: 1100
  - 2: 0100
  - 3: 0110
  - 4: 0010
  - 5: 0011
  - 6: 0001
  - 7: 1001
- Coil output:
  - In RUN and DONE, coil = table[position[2:0]].
  - In IDLE, coil = table[position[2:0]] if HOLD_IDLE, else 0000.
- position wraps two's-complement at POS_W. Targets are absolute, so there is no wrap in normal use.
- cmd_valid while not IDLE is ignored; the command is not queued.
- half_step or cmd_target changes after accept have no effect.

## Timing
- Reset values (sync, next edge):
  - state IDLE, position 0, coil 0000, cmd_ready 1, busy 0, done 0
  - aborting 0, ramp_steps 0, counter 0
- Reset mid-move wins over everything. Motion stops immediately.
- busy = 1 from the cycle after accept through the final RUN cycle. It is 0 in DONE and IDLE.
- First step occurs PERIOD_START cycles after accept. position and coil update on the same edge (registered).
- done pulses the cycle after the final step's edge; cmd_ready returns the cycle after that.
- Zero-distance command: done in the cycle after accept; busy stays 0.
- Back-to-back: the earliest next accept is 2 cycles after the final step.

## Test plan
- Reset: hold reset 3 cycles -> coil 0000, position 0, cmd_ready 1, busy 0, done 0.
- Half-step move, PERIOD_START=10, PERIOD_MIN=4, RAMP_DEC=2, target 5:
  - step edges 10, 18, 24, 32, 42 cycles after accept
  - coil 1100, 0100, 0110, 0010, 0011
  - done pulse at cycle 43; position 5
- Full-step move, same params, from 0 to target -6:
  - positions -2, -4, -6; coil 0001, 0010, 0100
  - intervals 10, 8, 10 (rem 2 > ramp 0 accelerate; rem 1 <= ramp 1 decelerate)
  - done once
- Zero distance: target = position = 0 -> done the cycle after accept; coil unchanged; busy never 1. A second cmd_valid during that DONE cycle is not accepted.
- Abort in cruise, target 100, same params:
  - assert abort after interval reaches 4 (ramp_steps 3)
  - next intervals 6, 8, 10; then done
  - final position 6 short of the no-abort trajectory, < 100; busy falls; HOLD_IDLE=0 gives coil 0000 in IDLE
- Reset mid-move at step 3 -> next edge position 0, coil 0000, busy 0, no done pulse. A new command is accepted normally afterwards.
